// File: rtl/pc_gen_btb.sv
// -----------------------------------------------------------------------------
// riscv_pkg / pc_gen_btb
//
// Fetch-stage PC generator with a direct-mapped branch target buffer (BTB).
// Each BTB entry holds a valid bit, a tag, a target and a 2-bit saturating
// direction counter. Lookup is combinational on the current fetch PC. Training
// comes from control-flow instructions resolved in EX.
//
// Next-PC priority (highest first):
//   rst -> RESET_PC, RedirectE -> RedirectPCE, StallF -> hold,
//   predicted taken -> PredTargetF, otherwise PCF + 4 (wraps modulo 2^XLEN).
//
// Parameters:
//   XLEN         datapath / PC width
//   RESET_PC     PCF value after reset
//   BTB_ENTRIES  number of BTB entries (power of 2, >= 2)
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   StallF         in   hold PCF
//   RedirectE      in   EX-stage correction, overrides StallF
//   RedirectPCE    in   corrected PC
//   UpdateE        in   resolved control-flow instruction in EX
//   UpdatePCE      in   PC of the resolved instruction
//   UpdateTakenE   in   actual direction
//   UpdateTargetE  in   actual target
//   PCF            out  current fetch PC (registered)
//   PredTakenF     out  BTB hit and counter predicts taken
//   PredTargetF    out  predicted target (meaningful when PredTakenF = 1)
// -----------------------------------------------------------------------------
package riscv_pkg;
  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
endpackage

module pc_gen_btb #(
  parameter int              XLEN        = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC    = riscv_pkg::RESET_PC,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            RedirectE,
  input  logic [XLEN-1:0] RedirectPCE,
  input  logic            UpdateE,
  input  logic [XLEN-1:0] UpdatePCE,
  input  logic            UpdateTakenE,
  input  logic [XLEN-1:0] UpdateTargetE,
  output logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup on the current fetch PC (zero latency)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx      = pc_q[IDX_W+1:2];
  assign lk_tag      = pc_q[XLEN-1:IDX_W+2];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign PredTakenF  = lk_hit && ctr_q[lk_idx][1];
  assign PredTargetF = target_q[lk_idx];
  assign PCF         = pc_q;

  // ---------------------------------------------------------------------------
  // Next PC
  // ---------------------------------------------------------------------------
  always_comb begin
    if (RedirectE) begin
      pc_d = RedirectPCE;
    end else if (StallF) begin
      pc_d = pc_q;
    end else if (PredTakenF) begin
      pc_d = PredTargetF;
    end else begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // ---------------------------------------------------------------------------
  // BTB training: one write port addressed by UpdatePCE
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             ent_we;
  logic [TAG_W-1:0] tag_d;
  logic [XLEN-1:0]  target_d;
  logic [1:0]       ctr_d;
  logic             unused_up_lsb;

  // The low two PC bits never take part in indexing or tagging.
  assign unused_up_lsb = ^UpdatePCE[1:0];

  assign up_idx = UpdatePCE[IDX_W+1:2];
  assign up_tag = UpdatePCE[XLEN-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    valid_d  = valid_q;
    ent_we   = 1'b0;
    tag_d    = up_tag;
    target_d = target_q[up_idx];
    ctr_d    = ctr_q[up_idx];

    if (UpdateE) begin
      if (up_hit) begin
        ent_we = 1'b1;
        if (UpdateTakenE) begin
          ctr_d    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
          target_d = UpdateTargetE;
        end else begin
          ctr_d    = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
        end
      end else if (UpdateTakenE) begin
        // Allocation evicts whatever aliased entry occupied this index.
        ent_we          = 1'b1;
        valid_d[up_idx] = 1'b1;
        target_d        = UpdateTargetE;
        ctr_d           = CTR_WEAK_TAKEN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: the entry payload (tag, target, counter) is deliberately not reset;
  // clearing the valid bits is enough to make every entry miss, and leaving the
  // arrays reset-free lets them map onto plain storage.
  always_ff @(posedge clk) begin
    if (!rst && ent_we) begin
      tag_q[up_idx]    <= tag_d;
      target_q[up_idx] <= target_d;
      ctr_q[up_idx]    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_pc_gen_btb.sv
// -----------------------------------------------------------------------------
// tb_pc_gen_btb
//
// Directed scenarios followed by a randomized phase. Expected values come from
// a behavioural model: each BTB slot remembers the full word address of the
// instruction it belongs to and an integer confidence 0..3, and the next PC is
// chosen by the plain priority rules.
// -----------------------------------------------------------------------------
module tb_pc_gen_btb;

  localparam int              XLEN = 32;
  localparam int              N    = 16;
  localparam logic [XLEN-1:0] RST_PC = '0;

  logic            clk = 1'b0;
  logic            rst;
  logic            StallF;
  logic            RedirectE;
  logic [XLEN-1:0] RedirectPCE;
  logic            UpdateE;
  logic [XLEN-1:0] UpdatePCE;
  logic            UpdateTakenE;
  logic [XLEN-1:0] UpdateTargetE;
  logic [XLEN-1:0] PCF;
  logic            PredTakenF;
  logic [XLEN-1:0] PredTargetF;

  pc_gen_btb #(
    .XLEN        (XLEN),
    .RESET_PC    (RST_PC),
    .BTB_ENTRIES (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .StallF        (StallF),
    .RedirectE     (RedirectE),
    .RedirectPCE   (RedirectPCE),
    .UpdateE       (UpdateE),
    .UpdatePCE     (UpdatePCE),
    .UpdateTakenE  (UpdateTakenE),
    .UpdateTargetE (UpdateTargetE),
    .PCF           (PCF),
    .PredTakenF    (PredTakenF),
    .PredTargetF   (PredTargetF)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [XLEN-1:0] m_pc;
  bit              m_valid [N];
  logic [XLEN-1:0] m_owner [N];   // full PC of the instruction owning the slot
  logic [XLEN-1:0] m_tgt   [N];
  int              m_conf  [N];   // 0..3, >= 2 means predict taken

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int slot(input logic [XLEN-1:0] pc);
    return int'((pc >> 2) % XLEN'(N));
  endfunction

  function automatic bit m_hit(input logic [XLEN-1:0] pc);
    int s = slot(pc);
    return m_valid[s] && ((m_owner[s] >> 2) == (pc >> 2));
  endfunction

  function automatic bit m_pred(input logic [XLEN-1:0] pc);
    return m_hit(pc) && (m_conf[slot(pc)] >= 2);
  endfunction

  task automatic set_idle();
    rst = 1'b0; StallF = 1'b0; RedirectE = 1'b0; RedirectPCE = '0;
    UpdateE = 1'b0; UpdatePCE = '0; UpdateTakenE = 1'b0; UpdateTargetE = '0;
  endtask

  // Check this cycle's combinational outputs, advance the model with the
  // driven inputs, clock once and check the new PCF.
  task automatic cycle();
    logic [XLEN-1:0] nxt;
    int s;
    check("pred_taken", PredTakenF, m_pred(m_pc));
    if (m_pred(m_pc)) check("pred_target", PredTargetF, m_tgt[slot(m_pc)]);

    if (rst)                nxt = RST_PC;
    else if (RedirectE)     nxt = RedirectPCE;
    else if (StallF)        nxt = m_pc;
    else if (m_pred(m_pc))  nxt = m_tgt[slot(m_pc)];
    else                    nxt = m_pc + 32'd4;

    if (rst) begin
      foreach (m_valid[k]) m_valid[k] = 1'b0;
    end else if (UpdateE) begin
      s = slot(UpdatePCE);
      if (m_hit(UpdatePCE)) begin
        if (UpdateTakenE) begin
          m_conf[s] = (m_conf[s] == 3) ? 3 : m_conf[s] + 1;
          m_tgt[s]  = UpdateTargetE;
        end else begin
          m_conf[s] = (m_conf[s] == 0) ? 0 : m_conf[s] - 1;
        end
      end else if (UpdateTakenE) begin
        m_valid[s] = 1'b1;
        m_owner[s] = UpdatePCE;
        m_tgt[s]   = UpdateTargetE;
        m_conf[s]  = 2;
      end
    end

    @(posedge clk);
    #1;
    m_pc = nxt;
    check("pcf", PCF, m_pc);
  endtask

  task automatic redirect_to(input logic [XLEN-1:0] pc, input logic stall);
    RedirectE = 1'b1; RedirectPCE = pc; StallF = stall;
    cycle();
    RedirectE = 1'b0;
  endtask

  task automatic upd(input logic [XLEN-1:0] pc, input logic taken,
                     input logic [XLEN-1:0] tgt);
    UpdateE = 1'b1; UpdatePCE = pc; UpdateTakenE = taken; UpdateTargetE = tgt;
    cycle();
    UpdateE = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] pool_pc();
    return XLEN'($urandom_range(0, 63)) << 2;
  endfunction

  initial begin
    set_idle();
    rst = 1'b1;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    m_pc = RST_PC;
    foreach (m_valid[k]) m_valid[k] = 1'b0;
    check("reset_pcf", PCF, 32'h0);
    check("reset_pred", PredTakenF, 1'b0);
    rst = 1'b0;

    // 1: free run 0x0 -> 0x4 -> 0x8 -> 0xC
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check("s1_seq", PCF, XLEN'(4 * k));
      check("s1_pred", PredTakenF, 1'b0);
    end

    // 2: stall at 0x8, then redirect overrides stall
    redirect_to(32'h8, 1'b0);
    StallF = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("s2_stall", PCF, 32'h8);
    end
    redirect_to(32'h100, 1'b1);
    check("s2_redirect_over_stall", PCF, 32'h100);

    // PC wraps to zero after the top word
    redirect_to(32'hFFFF_FFFC, 1'b0);
    StallF = 1'b0;
    cycle();
    check("wrap", PCF, 32'h0);

    // 3: train 0x10 -> 0x80, then fetch from 0x10
    StallF = 1'b1;
    upd(32'h10, 1'b1, 32'h80);
    redirect_to(32'h10, 1'b1);
    check("s3_hit", PredTakenF, 1'b1);
    check("s3_target", PredTargetF, 32'h80);
    StallF = 1'b0;
    cycle();
    check("s3_follow", PCF, 32'h80);

    // Same-cycle lookup during the write sees the old (invalid) entry
    redirect_to(32'h20, 1'b1);
    UpdateE = 1'b1; UpdatePCE = 32'h20; UpdateTakenE = 1'b1; UpdateTargetE = 32'h300;
    #1;
    check("s3_same_cycle_miss", PredTakenF, 1'b0);
    cycle();
    UpdateE = 1'b0;
    #1;
    check("s3_next_cycle_hit", PredTakenF, 1'b1);
    check("s3_next_cycle_tgt", PredTargetF, 32'h300);

    // 4: hysteresis on 0x10 (starts weak taken)
    redirect_to(32'h10, 1'b1);
    upd(32'h10, 1'b0, 32'h0);
    check("s4_weak_nt", PredTakenF, 1'b0);
    upd(32'h10, 1'b1, 32'h80);
    check("s4_weak_t", PredTakenF, 1'b1);
    for (int k = 0; k < 3; k++) upd(32'h10, 1'b1, 32'h80);
    upd(32'h10, 1'b0, 32'h0);
    check("s4_strong_then_nt", PredTakenF, 1'b1);
    check("s4_target_kept", PredTargetF, 32'h80);

    // 5: aliasing on index 4
    redirect_to(32'h50, 1'b1);
    check("s5_alias_miss", PredTakenF, 1'b0);
    upd(32'h50, 1'b1, 32'h200);
    check("s5_alias_hit", PredTakenF, 1'b1);
    check("s5_alias_tgt", PredTargetF, 32'h200);
    redirect_to(32'h10, 1'b1);
    check("s5_evicted", PredTakenF, 1'b0);
    upd(32'h90, 1'b0, 32'h0);
    redirect_to(32'h90, 1'b1);
    check("s5_no_alloc", PredTakenF, 1'b0);
    redirect_to(32'h50, 1'b1);
    check("s5_still_50", PredTakenF, 1'b1);

    // 6: single-cycle reset with a simultaneous update
    upd(32'h10, 1'b1, 32'h80);
    rst = 1'b1;
    UpdateE = 1'b1; UpdatePCE = 32'h30; UpdateTakenE = 1'b1; UpdateTargetE = 32'h400;
    cycle();
    set_idle();
    StallF = 1'b1;
    check("s6_reset_pcf", PCF, 32'h0);
    redirect_to(32'h10, 1'b1);
    check("s6_invalidated", PredTakenF, 1'b0);
    redirect_to(32'h30, 1'b1);
    check("s6_update_dropped", PredTakenF, 1'b0);

    // Randomized phase
    set_idle();
    for (int k = 0; k < 400; k++) begin
      rst          = ($urandom_range(0, 49) == 0);
      RedirectE    = ($urandom_range(0, 7) == 0);
      RedirectPCE  = pool_pc();
      StallF       = ($urandom_range(0, 3) == 0);
      UpdateE      = ($urandom_range(0, 2) == 0);
      UpdatePCE    = pool_pc();
      UpdateTakenE = ($urandom_range(0, 2) != 0);
      UpdateTargetE = pool_pc();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
